paddle_encoder: RTL and testbench
=================================

# paddle_encoder

Parametrised rotary-encoder paddle controller for the pong game engine. It synchronises and filters the raw quadrature pins, decodes edges into detents with a signed sub-detent accumulator, and keeps a saturating detent count. Optional speed acceleration is supported. A recentre command is provided. It drives a scaled, registered paddle position plus a change strobe straight into the game engine, one instance per player.

## Interface
- POS_WIDTH, 9 — width of POSITION.
- MAX_DETENTS, 25 — upper saturation limit of the detent count; lower limit is 0.
- STEP, 16 — position units per detent; STEP*MAX_DETENTS must be ≤ 2^POS_WIDTH−1 (elaboration-time check, fail if violated).
- EDGES_PER_DETENT, 4 — valid quadrature edges per mechanical click; ≥1.
- FILTER_CYCLES, 3 — consecutive identical synchronised samples required before the filtered A/B state updates; ≥1.
- ACCEL_ENABLE, 1 — 1 enables double-stepping on fast rotation.
- ACCEL_WINDOW, 50000 — a same-direction detent arriving fewer than this many cycles after the previous detent is a fast detent.
- CLOCK  in  1  system clock; all state on rising edge.
- RESET  in  1  asynchronous, active-low reset (asserted when 0).
- A, B  in  1 each  raw encoder pins, asynchronous to CLOCK.
- CENTER  in  1  synchronous pulse; recentres the paddle.
- DETENT  out  $clog2(MAX_DETENTS+1)  current detent count.
- POSITION  out  POS_WIDTH  DETENT*STEP, registered.
- MOVED  out  1  one-cycle strobe, high in the cycle POSITION takes a new, different value.

## Operation
- Reset (RESET=0, immediate) clears the following to 0:
  - synchronisers, filtered state, filter counter and accumulator;
  - DETENT, POSITION and MOVED;
  - last-direction, set to up.
- Interval counter resets to saturated (ACCEL_WINDOW).
- Synchroniser: two flops per pin, no further logic on raw pins.
- Filter: the filtered AB pair loads the synchronised pair once it has been identical for FILTER_CYCLES consecutive samples. Pairs are filtered jointly, not per pin.
- Decode, on each filtered-state change old→new:
  - Sequence 00→01→11→10→00 is +1 edge (up); the reverse is −1.
  - Both bits changing is illegal: ignored, no accumulator change.
  - After reset a resting encoder at 11 appears as 00→11, which is illegal, so no spurious movement results.
- Accumulator (signed, range ±(EDGES_PER_DETENT−1)):
  - Adds the edge.
  - Reaching +EDGES_PER_DETENT: clear to 0 and issue an up detent.
  - Reaching −EDGES_PER_DETENT: clear to 0 and issue a down detent.
  - Partial reversals count back without issuing a detent.
- Detent step size:
  - 2 if ACCEL_ENABLE=1, the interval counter < ACCEL_WINDOW, and the direction equals last-direction.
  - Otherwise 1.
- Detent application:
  - The step is applied with saturation to [0, MAX_DETENTS]; no wrap-around.
  - On any issued detent, the interval counter clears to 0 and last-direction updates, even when DETENT is saturated.
  - The interval counter otherwise increments, saturating at ACCEL_WINDOW.
- CENTER=1:
  - DETENT ← MAX_DETENTS/2 (floor), accumulator ← 0, interval counter ← ACCEL_WINDOW.
  - It takes priority over a detent issued in the same cycle; that detent is discarded.
- POSITION ← DETENT*STEP one cycle after DETENT changes. MOVED=1 in that same cycle only if the new value differs from the old one.
- Saturated steps and a CENTER that leaves DETENT unchanged produce no MOVED.

## Timing
- Edge n: a new stable A/B level is first sampled by the first synchroniser flop.
- Filtered state updates at edge n+1+FILTER_CYCLES.
- Accumulator and DETENT update at edge n+2+FILTER_CYCLES.
- POSITION and MOVED update at edge n+3+FILTER_CYCLES.
- Glitches shorter than FILTER_CYCLES clocks after synchronisation have no effect.
- CENTER sampled at edge m: DETENT updates at m; POSITION and MOVED update at m+1.
- MOVED is exactly one cycle wide per change; back-to-back changes give back-to-back strobes.
- Reset mid-rotation discards the partial accumulator. The next full detent after release counts from the first legal edge.
- Throughput: one edge per FILTER_CYCLES+1 clocks maximum; faster input is undefined.

## Test plan
- Reset with A=B=1 held, then release and wait 20 cycles → DETENT=0, POSITION=0, MOVED never high.
- ACCEL_ENABLE=0, A/B held 10 cycles per state, one full up sequence 00→01→11→10→00 → DETENT=1, POSITION=16, single MOVED exactly 6 clocks after the final A/B transition is first sampled.
- 30 slow up detents → DETENT saturates at 25, POSITION=400, exactly 25 MOVED pulses. Then one down detent → POSITION=384.
- Two up edges then two down edges, followed by a 1-cycle glitch on A → DETENT unchanged, accumulator 0, no MOVED.
- ACCEL_ENABLE=1, ACCEL_WINDOW=100: two up detents 60 cycles apart from DETENT=0 → DETENT 1 then 3. A down detent 60 cycles later → DETENT 2 (reversal, single step).
- CENTER pulsed at DETENT=7, in the same cycle as an issued up detent → DETENT=12, POSITION=192, one MOVED. A second CENTER → no MOVED.

Source files
------------

// File: rtl/paddle_encoder.sv
// -----------------------------------------------------------------------------
// paddle_encoder
//
// Rotary-encoder paddle controller for the pong game engine, one instance per
// player. The raw quadrature pins are synchronised, filtered as a pair and
// decoded into signed edges. A sub-detent accumulator turns edges into detents,
// which move a saturating detent count, optionally double-stepping when the
// encoder is spun quickly in one direction. The count is scaled into a
// registered paddle position with a one-cycle change strobe.
//
// Parameters
//   POS_WIDTH         width of POSITION
//   MAX_DETENTS       upper limit of the detent count (lower limit is 0)
//   STEP              position units per detent
//   EDGES_PER_DETENT  legal quadrature edges per mechanical click (>= 1)
//   FILTER_CYCLES     identical synchronised samples needed to accept a new
//                     A/B pair (>= 1)
//   ACCEL_ENABLE      1 enables double-stepping on fast rotation
//   ACCEL_WINDOW      a same-direction detent arriving sooner than this many
//                     cycles after the previous detent counts as fast
//
// Ports
//   CLOCK     in   system clock, all state on the rising edge
//   RESET     in   asynchronous reset, active low
//   A, B      in   raw encoder pins, asynchronous to CLOCK
//   CENTER    in   synchronous recentre pulse
//   DETENT    out  current detent count
//   POSITION  out  DETENT*STEP, registered
//   MOVED     out  one-cycle strobe when POSITION takes a different value
// -----------------------------------------------------------------------------
module paddle_encoder #(
  parameter int POS_WIDTH        = 9,
  parameter int MAX_DETENTS      = 25,
  parameter int STEP             = 16,
  parameter int EDGES_PER_DETENT = 4,
  parameter int FILTER_CYCLES    = 3,
  parameter int ACCEL_ENABLE     = 1,
  parameter int ACCEL_WINDOW     = 50000
) (
  input  logic                               CLOCK,
  input  logic                               RESET,
  input  logic                               A,
  input  logic                               B,
  input  logic                               CENTER,
  output logic [$clog2(MAX_DETENTS+1)-1:0]   DETENT,
  output logic [POS_WIDTH-1:0]               POSITION,
  output logic                               MOVED
);

  localparam int DW = $clog2(MAX_DETENTS + 1);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int AW = $clog2(EDGES_PER_DETENT + 1) + 1;
  localparam int IW = $clog2(ACCEL_WINDOW + 1);

  localparam logic [FW-1:0]        RUN_ONE  = FW'(1);
  localparam logic [FW-1:0]        RUN_MAX  = FW'(FILTER_CYCLES);
  localparam logic signed [AW-1:0] ACC_ONE  = AW'(1);
  localparam logic signed [AW-1:0] ACC_TOP  = AW'(EDGES_PER_DETENT);
  localparam logic signed [AW-1:0] ACC_BOT  = AW'(-EDGES_PER_DETENT);
  localparam logic [DW-1:0]        DET_MAX  = DW'(MAX_DETENTS);
  localparam logic [DW-1:0]        DET_MID  = DW'(MAX_DETENTS / 2);
  localparam logic [IW-1:0]        IVL_MAX  = IW'(ACCEL_WINDOW);
  localparam logic [POS_WIDTH-1:0] STEP_P   = POS_WIDTH'(STEP);

  // Elaboration-time parameter sanity checks.
  if (longint'(STEP) * longint'(MAX_DETENTS) > (longint'(1) << POS_WIDTH) - 1) begin : g_bad_range
    $error("paddle_encoder: STEP*MAX_DETENTS does not fit in POS_WIDTH bits");
  end
  if (EDGES_PER_DETENT < 1 || FILTER_CYCLES < 1 || ACCEL_WINDOW < 1 || MAX_DETENTS < 1) begin : g_bad_param
    $error("paddle_encoder: EDGES_PER_DETENT, FILTER_CYCLES, ACCEL_WINDOW and MAX_DETENTS must be >= 1");
  end

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Position of an A/B pair along the up sequence 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Synchroniser and joint A/B filter
  // ---------------------------------------------------------------------------
  logic [1:0]    sync1, sync2;
  logic [1:0]    last_ab;      // previous synchronised sample, for run length
  logic [FW-1:0] run;          // consecutive identical samples, saturating
  logic [FW-1:0] run_next;
  logic [1:0]    filt;         // accepted A/B pair
  logic [1:0]    filt_prev;    // accepted pair one cycle earlier

  always_comb begin
    if (sync2 != last_ab)  run_next = RUN_ONE;
    else if (run == RUN_MAX) run_next = RUN_MAX;
    else                   run_next = run + RUN_ONE;
  end

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sync1     <= '0;
      sync2     <= '0;
      last_ab   <= '0;
      run       <= '0;
      filt      <= '0;
      filt_prev <= '0;
    end else begin
      sync1     <= {A, B};
      sync2     <= sync1;
      last_ab   <= sync2;
      run       <= run_next;
      filt_prev <= filt;
      // Reloading the same pair while it stays stable is harmless.
      if (run_next == RUN_MAX) filt <= sync2;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge decode: a step of +1 along the sequence is up, -1 is down; a step of
  // 2 means both pins changed together and is ignored.
  // ---------------------------------------------------------------------------
  logic [1:0] pos_diff;
  logic       edge_up, edge_dn;

  always_comb begin
    pos_diff = gray_pos(filt) - gray_pos(filt_prev);
    edge_up  = (pos_diff == 2'd1);
    edge_dn  = (pos_diff == 2'd3);
  end

  // ---------------------------------------------------------------------------
  // Accumulator, acceleration and detent count
  // ---------------------------------------------------------------------------
  logic signed [AW-1:0] acc, acc_sum, acc_next;
  logic                 det_up, det_dn;
  dir_t                 last_dir, dir_new, dir_next;
  logic [IW-1:0]        interval, ivl_next;
  logic                 fast;
  logic [DW:0]          step_mag;
  logic [DW:0]          det_ext, up_sum, dn_diff;
  logic [DW-1:0]        det_next;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    acc_sum  = acc;
    det_up   = 1'b0;
    det_dn   = 1'b0;
    dir_new  = DIR_UP;
    fast     = 1'b0;
    step_mag = '0;
    det_ext  = {1'b0, DETENT};
    up_sum   = '0;
    dn_diff  = '0;
    det_next = DETENT;
    dir_next = last_dir;
    ivl_next = (interval == IVL_MAX) ? IVL_MAX : interval + IW'(1);

    if (edge_up)      acc_sum = acc + ACC_ONE;
    else if (edge_dn) acc_sum = acc - ACC_ONE;

    det_up   = edge_up && (acc_sum == ACC_TOP);
    det_dn   = edge_dn && (acc_sum == ACC_BOT);
    acc_next = (det_up || det_dn) ? '0 : acc_sum;

    dir_new  = det_dn ? DIR_DOWN : DIR_UP;
    fast     = (ACCEL_ENABLE != 0) && (interval < IVL_MAX) && (dir_new == last_dir);
    step_mag = fast ? (DW+1)'(2) : (DW+1)'(1);
    up_sum   = det_ext + step_mag;
    dn_diff  = det_ext - step_mag;

    if (det_up || det_dn) begin
      // Interval and direction track every detent, even a saturated one.
      ivl_next = '0;
      dir_next = dir_new;
      if (det_up) det_next = (up_sum > {1'b0, DET_MAX}) ? DET_MAX : up_sum[DW-1:0];
      else        det_next = (det_ext < step_mag) ? '0 : dn_diff[DW-1:0];
    end

    // Recentre wins over a detent issued in the same cycle; that detent, and
    // its direction, are dropped.
    if (CENTER) begin
      det_next = DET_MID;
      acc_next = '0;
      ivl_next = IVL_MAX;
      dir_next = last_dir;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      acc      <= '0;
      DETENT   <= '0;
      last_dir <= DIR_UP;
      interval <= IVL_MAX;
    end else begin
      acc      <= acc_next;
      DETENT   <= det_next;
      last_dir <= dir_next;
      interval <= ivl_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Scaled position and change strobe, one cycle behind DETENT
  // ---------------------------------------------------------------------------
  logic [POS_WIDTH-1:0] pos_next;

  always_comb begin
    pos_next = POS_WIDTH'(DETENT) * STEP_P;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      POSITION <= '0;
      MOVED    <= 1'b0;
    end else begin
      POSITION <= pos_next;
      MOVED    <= (pos_next != POSITION);
    end
  end

endmodule

// File: tb/tb_paddle_encoder.sv
// -----------------------------------------------------------------------------
// tb_paddle_encoder
//
// Directed bench for paddle_encoder. dut_slow runs with acceleration off,
// dut_fast with acceleration on and a 100-cycle window; both share pins.
// Inputs change on the falling clock edge, outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_paddle_encoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       a, b, center;

  logic [4:0] det_s, det_f;
  logic [8:0] pos_s, pos_f;
  logic       moved_s, moved_f;

  int         n_cmp   = 0;
  int         n_bad   = 0;
  int         moved_cnt = 0;
  logic [1:0] cur_ab;

  always #5 clock = ~clock;

  paddle_encoder #(
    .POS_WIDTH(9), .MAX_DETENTS(25), .STEP(16), .EDGES_PER_DETENT(4),
    .FILTER_CYCLES(3), .ACCEL_ENABLE(0), .ACCEL_WINDOW(50000)
  ) dut_slow (
    .CLOCK(clock), .RESET(reset), .A(a), .B(b), .CENTER(center),
    .DETENT(det_s), .POSITION(pos_s), .MOVED(moved_s)
  );

  paddle_encoder #(
    .POS_WIDTH(9), .MAX_DETENTS(25), .STEP(16), .EDGES_PER_DETENT(4),
    .FILTER_CYCLES(3), .ACCEL_ENABLE(1), .ACCEL_WINDOW(100)
  ) dut_fast (
    .CLOCK(clock), .RESET(reset), .A(a), .B(b), .CENTER(center),
    .DETENT(det_f), .POSITION(pos_f), .MOVED(moved_f)
  );

  // Each high cycle of MOVED is counted at the rising edge that ends it.
  always @(posedge clock) if (moved_s === 1'b1) moved_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [1:0] gray_next(input logic [1:0] ab, input bit up);
    case (ab)
      2'b00:   return up ? 2'b01 : 2'b10;
      2'b01:   return up ? 2'b11 : 2'b00;
      2'b11:   return up ? 2'b10 : 2'b01;
      default: return up ? 2'b00 : 2'b11;
    endcase
  endfunction

  task automatic drive_edge(input bit up, input int hold);
    cur_ab = gray_next(cur_ab, up);
    {a, b} = cur_ab;
    wait_cyc(hold);
  endtask

  task automatic detent(input bit up, input int hold);
    repeat (4) drive_edge(up, hold);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(5);
  endtask

  initial begin
    // Reset with the encoder resting at 11.
    cur_ab = 2'b11;
    {a, b} = cur_ab;
    center = 1'b0;
    reset  = 1'b0;
    wait_cyc(3);
    check("rst_detent", det_s, 0);
    check("rst_position", pos_s, 0);
    check("rst_moved", moved_s, 0);
    reset = 1'b1;
    moved_cnt = 0;
    wait_cyc(20);
    check("rest11_detent", det_s, 0);
    check("rest11_position", pos_s, 0);
    check("rest11_moved_cnt", moved_cnt, 0);

    // 11 -> 00 is illegal; then one full slow up sequence.
    cur_ab = 2'b00;
    {a, b} = cur_ab;
    wait_cyc(10);
    moved_cnt = 0;
    repeat (3) drive_edge(1'b1, 10);
    cur_ab = gray_next(cur_ab, 1'b1);
    {a, b} = cur_ab;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      check($sformatf("moved_at_%0d", k), moved_s, (k == 7) ? 1 : 0);
    end
    check("one_detent", det_s, 1);
    check("one_position", pos_s, 16);
    check("one_moved_cnt", moved_cnt, 1);

    // Mid-run reset clears the count.
    reset = 1'b0;
    wait_cyc(2);
    check("midrst_detent", det_s, 0);
    check("midrst_position", pos_s, 0);
    reset = 1'b1;
    wait_cyc(5);

    // Thirty up detents saturate at 25, then one down detent.
    moved_cnt = 0;
    repeat (30) detent(1'b1, 6);
    wait_cyc(10);
    check("sat_detent", det_s, 25);
    check("sat_position", pos_s, 400);
    check("sat_moved_cnt", moved_cnt, 25);
    moved_cnt = 0;
    detent(1'b0, 6);
    wait_cyc(10);
    check("down_detent", det_s, 24);
    check("down_position", pos_s, 384);
    check("down_moved_cnt", moved_cnt, 1);

    // Partial reversal plus a one-cycle glitch on A.
    moved_cnt = 0;
    repeat (2) drive_edge(1'b1, 6);
    repeat (2) drive_edge(1'b0, 6);
    a = ~cur_ab[1];
    wait_cyc(1);
    a = cur_ab[1];
    wait_cyc(10);
    check("glitch_detent", det_s, 24);
    check("glitch_moved_cnt", moved_cnt, 0);
    // Three more up edges: only a zeroed accumulator stays below a detent.
    repeat (3) drive_edge(1'b1, 6);
    wait_cyc(10);
    check("partial_detent", det_s, 24);
    check("partial_moved_cnt", moved_cnt, 0);
    drive_edge(1'b1, 6);
    wait_cyc(10);
    check("complete_detent", det_s, 25);
    check("complete_position", pos_s, 400);
    check("complete_moved_cnt", moved_cnt, 1);

    // Bring the count down to 7, then collide CENTER with an up detent.
    repeat (18) detent(1'b0, 6);
    wait_cyc(10);
    check("seven_detent", det_s, 7);
    check("seven_position", pos_s, 112);
    moved_cnt = 0;
    repeat (3) drive_edge(1'b1, 6);
    cur_ab = gray_next(cur_ab, 1'b1);
    {a, b} = cur_ab;
    wait_cyc(5);
    center = 1'b1;
    wait_cyc(1);
    center = 1'b0;
    check("center_detent", det_s, 12);
    wait_cyc(5);
    check("center_position", pos_s, 192);
    check("center_moved_cnt", moved_cnt, 1);
    moved_cnt = 0;
    center = 1'b1;
    wait_cyc(1);
    center = 1'b0;
    wait_cyc(5);
    check("center2_detent", det_s, 12);
    check("center2_position", pos_s, 192);
    check("center2_moved_cnt", moved_cnt, 0);

    // Acceleration: detents 60 cycles apart on the fast instance.
    pulse_reset();
    check("accel_rst_detent", det_f, 0);
    detent(1'b1, 15);
    check("accel_first", det_f, 1);
    detent(1'b1, 15);
    check("accel_double", det_f, 3);
    check("accel_double_pos", pos_f, 48);
    detent(1'b0, 15);
    check("accel_reversal", det_f, 2);
    wait_cyc(150);
    detent(1'b0, 15);
    check("accel_slow_down", det_f, 1);
    detent(1'b0, 15);
    check("accel_floor_detent", det_f, 0);
    check("accel_floor_pos", pos_f, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
